// File: rtl/imu_link_supervisor.sv
// Link supervisor between the SPI packet parser and motion processing: qualifies
// packets, tracks link health (DOWN/ACQ/LINKED/FAULT) and holds the newest frame.
module imu_link_supervisor #(
  parameter int TIMEOUT_CYC = 30000,
  parameter int ACQ_PKTS    = 3,
  parameter int MAX_ERR     = 4,
  parameter int HOLDOFF_CYC = 3000,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pkt_done,
  input  logic               hdr_ok,
  input  logic               euler_ok,
  input  logic               gyro_ok,
  input  logic signed [15:0] roll,
  input  logic signed [15:0] pitch,
  input  logic signed [15:0] yaw,
  input  logic signed [15:0] gx,
  input  logic signed [15:0] gy,
  input  logic signed [15:0] gz,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic signed [15:0] f_roll,
  output logic signed [15:0] f_pitch,
  output logic signed [15:0] f_yaw,
  output logic signed [15:0] f_gx,
  output logic signed [15:0] f_gy,
  output logic signed [15:0] f_gz,
  output logic               f_gyro_ok,
  output logic [1:0]         link_state,
  output logic               link_up,
  output logic               timeout_pulse,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   overrun_cnt
);

  typedef enum logic [1:0] {
    DOWN   = 2'd0,
    ACQ    = 2'd1,
    LINKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_CYC + 1);
  localparam int ACQ_W  = $clog2(ACQ_PKTS + 1);
  localparam int ERR_W  = $clog2(MAX_ERR + 1);

  // Reset asserts immediately but releases two clock edges after rst_n rises.
  logic [1:0] rst_pipe_reg;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe_reg <= 2'b00;
    else        rst_pipe_reg <= {rst_pipe_reg[0], 1'b1};
  end

  assign rst_sync_n = rst_pipe_reg[1];

  state_t              state_reg;
  logic [TMR_W-1:0]    timer_reg;
  logic [HOLD_W-1:0]   hold_reg;
  logic [ACQ_W-1:0]    acq_cnt_reg;
  logic [ERR_W-1:0]    err_run_reg;

  logic good, bad, timer_expired, capture;

  assign good          = pkt_done & hdr_ok;
  assign bad           = pkt_done & ~hdr_ok;
  // A packet in the expiry cycle wins over the timeout.
  assign timer_expired = ~pkt_done && (timer_reg == TMR_W'(TIMEOUT_CYC - 1));
  assign capture       = good & euler_ok & (state_reg == LINKED);
  assign link_state    = state_reg;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_reg     <= DOWN;
      link_up       <= 1'b0;
      timeout_pulse <= 1'b0;
      timer_reg     <= '0;
      hold_reg      <= '0;
      acq_cnt_reg   <= '0;
      err_run_reg   <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state_reg)
        DOWN: begin
          timer_reg <= '0;
          if (good) begin
            if (ACQ_PKTS <= 1) begin
              state_reg   <= LINKED;
              link_up     <= 1'b1;
              err_run_reg <= '0;
            end else begin
              state_reg   <= ACQ;
              acq_cnt_reg <= ACQ_W'(1);
            end
          end
        end
        ACQ: begin
          if (good) begin
            timer_reg <= '0;
            if (acq_cnt_reg == ACQ_W'(ACQ_PKTS - 1)) begin
              state_reg   <= LINKED;
              link_up     <= 1'b1;
              err_run_reg <= '0;
              acq_cnt_reg <= '0;
            end else begin
              acq_cnt_reg <= acq_cnt_reg + 1'b1;
            end
          end else if (bad || timer_expired) begin
            state_reg     <= DOWN;
            timeout_pulse <= timer_expired;
            timer_reg     <= '0;
            acq_cnt_reg   <= '0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        LINKED: begin
          if (good) begin
            timer_reg   <= '0;
            err_run_reg <= '0;
          end else if (bad) begin
            timer_reg <= '0;
            if (err_run_reg == ERR_W'(MAX_ERR - 1)) begin
              state_reg   <= FAULT;
              link_up     <= 1'b0;
              hold_reg    <= '0;
              err_run_reg <= '0;
            end else begin
              err_run_reg <= err_run_reg + 1'b1;
            end
          end else if (timer_expired) begin
            state_reg     <= DOWN;
            link_up       <= 1'b0;
            timeout_pulse <= 1'b1;
            timer_reg     <= '0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        FAULT: begin
          timer_reg <= '0;
          if (hold_reg == HOLD_W'(HOLDOFF_CYC - 1)) begin
            state_reg <= DOWN;
            hold_reg  <= '0;
          end else begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
        default: state_reg <= DOWN;
      endcase
    end
  end

  // Newest frame wins; a capture coinciding with a handshake is not an overrun.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      frame_valid <= 1'b0;
      f_roll      <= '0;
      f_pitch     <= '0;
      f_yaw       <= '0;
      f_gx        <= '0;
      f_gy        <= '0;
      f_gz        <= '0;
      f_gyro_ok   <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      if (capture) begin
        frame_valid <= 1'b1;
        f_roll      <= roll;
        f_pitch     <= pitch;
        f_yaw       <= yaw;
        f_gx        <= gx;
        f_gy        <= gy;
        f_gz        <= gz;
        f_gyro_ok   <= gyro_ok;
        if (frame_valid && !frame_ready && (overrun_cnt != {CNT_W{1'b1}}))
          overrun_cnt <= overrun_cnt + 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n)
      err_cnt <= '0;
    else if (bad && (err_cnt != {CNT_W{1'b1}}))
      err_cnt <= err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_imu_link_supervisor.sv
// Bench for imu_link_supervisor: directed scenarios plus randomized traffic
// compared each cycle against a timestamp-based reference model.
module tb_imu_link_supervisor;

  localparam int TIMEOUT_CYC = 30000;
  localparam int ACQ_PKTS    = 3;
  localparam int MAX_ERR     = 4;
  localparam int HOLDOFF_CYC = 3000;
  localparam int CNT_W       = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk, rst_n, pkt_done, hdr_ok, euler_ok, gyro_ok, frame_ready;
  logic signed [15:0] roll, pitch, yaw, gx, gy, gz;
  logic frame_valid, f_gyro_ok, link_up, timeout_pulse;
  logic signed [15:0] f_roll, f_pitch, f_yaw, f_gx, f_gy, f_gz;
  logic [1:0] link_state;
  logic [CNT_W-1:0] err_cnt, overrun_cnt;

  imu_link_supervisor #(
    .TIMEOUT_CYC(TIMEOUT_CYC), .ACQ_PKTS(ACQ_PKTS), .MAX_ERR(MAX_ERR),
    .HOLDOFF_CYC(HOLDOFF_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pkt_done(pkt_done), .hdr_ok(hdr_ok),
    .euler_ok(euler_ok), .gyro_ok(gyro_ok), .roll(roll), .pitch(pitch),
    .yaw(yaw), .gx(gx), .gy(gy), .gz(gz), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .f_roll(f_roll), .f_pitch(f_pitch),
    .f_yaw(f_yaw), .f_gx(f_gx), .f_gy(f_gy), .f_gz(f_gz),
    .f_gyro_ok(f_gyro_ok), .link_state(link_state), .link_up(link_up),
    .timeout_pulse(timeout_pulse), .err_cnt(err_cnt), .overrun_cnt(overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: link decisions from packet timestamps, not a cycle timer.
  int m_state, m_good_run, m_bad_run, m_cyc, m_last_pkt, m_fault_start, m_rel;
  int m_err, m_ovr;
  logic m_fv, m_pulse, m_gok;
  logic signed [15:0] m_roll, m_pitch, m_yaw, m_gx, m_gy, m_gz;

  always @(posedge clk) begin
    if (!rst_n || m_rel < 2) begin
      if (!rst_n) m_rel = 0;
      else        m_rel = m_rel + 1;
      m_state = 0; m_good_run = 0; m_bad_run = 0; m_cyc = 0; m_last_pkt = 0;
      m_fault_start = 0; m_err = 0; m_ovr = 0; m_fv = 0; m_pulse = 0; m_gok = 0;
      m_roll = 0; m_pitch = 0; m_yaw = 0; m_gx = 0; m_gy = 0; m_gz = 0;
    end else begin
      m_cyc = m_cyc + 1;
      m_pulse = 0;
      if (pkt_done && !hdr_ok && m_err < CNT_MAX) m_err = m_err + 1;
      if (pkt_done && hdr_ok && euler_ok && m_state == 2) begin
        if (m_fv && !frame_ready && m_ovr < CNT_MAX) m_ovr = m_ovr + 1;
        m_fv = 1; m_gok = gyro_ok;
        m_roll = roll; m_pitch = pitch; m_yaw = yaw; m_gx = gx; m_gy = gy; m_gz = gz;
      end else if (m_fv && frame_ready) begin
        m_fv = 0;
      end
      if (m_state == 0) begin
        if (pkt_done && hdr_ok) begin m_state = 1; m_good_run = 1; end
      end else if (m_state == 3) begin
        if (m_cyc - m_fault_start == HOLDOFF_CYC) m_state = 0;
      end else if (pkt_done && hdr_ok) begin
        m_bad_run = 0;
        if (m_state == 1) begin
          m_good_run = m_good_run + 1;
          if (m_good_run == ACQ_PKTS) m_state = 2;
        end
      end else if (pkt_done) begin
        if (m_state == 1) m_state = 0;
        else begin
          m_bad_run = m_bad_run + 1;
          if (m_bad_run == MAX_ERR) begin m_state = 3; m_fault_start = m_cyc; m_bad_run = 0; end
        end
      end else if (m_cyc - m_last_pkt == TIMEOUT_CYC) begin
        m_state = 0; m_pulse = 1;
      end
      if (pkt_done) m_last_pkt = m_cyc;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pkt(input logic hdr, input logic [1:0] flags,
                          input logic signed [15:0] r, p, y, x, yy, z);
    pkt_done = 1'b1; hdr_ok = hdr; euler_ok = flags[0]; gyro_ok = flags[1];
    roll = r; pitch = p; yaw = y; gx = x; gy = yy; gz = z;
    @(negedge clk);
    pkt_done = 1'b0; hdr_ok = 1'b0; euler_ok = 1'b0; gyro_ok = 1'b0;
  endtask

  task automatic acquire();
    for (int i = 0; i < ACQ_PKTS; i++) begin
      send_pkt(1'b1, 2'b00, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
      idle(1);
    end
  endtask

  task automatic test_reset();
    idle(3);
    checks++; if (link_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", link_state); end
    checks++; if (link_up !== 1'b0 || timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset_flags got up=%b to=%b want 0 0", link_up, timeout_pulse); end
    checks++; if (frame_valid !== 1'b0 || f_roll !== 16'sd0 || f_gyro_ok !== 1'b0) begin errors++; $display("FAIL reset_frame got v=%b roll=%0d g=%b want 0", frame_valid, f_roll, f_gyro_ok); end
    checks++; if (err_cnt !== '0 || overrun_cnt !== '0) begin errors++; $display("FAIL reset_cnt got err=%0d ovr=%0d want 0 0", err_cnt, overrun_cnt); end
    rst_n = 1'b1;
    idle(3);
    checks++; if (link_state !== 2'd0) begin errors++; $display("FAIL release_state got %0d want 0", link_state); end
    $display("test_reset done");
  endtask

  task automatic test_acquisition();
    frame_ready = 1'b1;
    for (int i = 0; i < ACQ_PKTS; i++) begin
      send_pkt(1'b1, 2'b01, 16'sd7, 16'sd8, 16'sd9, 16'sd1, 16'sd2, 16'sd3);
      if (i < ACQ_PKTS - 1) begin
        checks++; if (link_state !== 2'd1 || link_up !== 1'b0) begin errors++; $display("FAIL acq_pkt%0d got st=%0d up=%b want 1 0", i, link_state, link_up); end
        idle(2999);
      end else begin
        checks++; if (link_state !== 2'd2 || link_up !== 1'b1) begin errors++; $display("FAIL acq_linked got st=%0d up=%b want 2 1", link_state, link_up); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL acq_nocapture got valid=%b want 0", frame_valid); end
      end
    end
    idle(2999);
    send_pkt(1'b1, 2'b11, 16'sd1000, -16'sd500, 16'sd2000, 16'sd100, -16'sd200, 16'sd50);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL cap_valid got %b want 1", frame_valid); end
    checks++; if (f_roll !== 16'sd1000 || f_pitch !== -16'sd500 || f_yaw !== 16'sd2000) begin errors++; $display("FAIL cap_euler got %0d %0d %0d want 1000 -500 2000", f_roll, f_pitch, f_yaw); end
    checks++; if (f_gx !== 16'sd100 || f_gy !== -16'sd200 || f_gz !== 16'sd50 || f_gyro_ok !== 1'b1) begin errors++; $display("FAIL cap_gyro got %0d %0d %0d g=%b want 100 -200 50 1", f_gx, f_gy, f_gz, f_gyro_ok); end
    idle(1);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL cap_consumed got valid=%b want 0", frame_valid); end
    $display("test_acquisition done");
  endtask

  task automatic test_flags_timeout();
    idle(4999);
    send_pkt(1'b1, 2'b10, 16'sd111, 16'sd222, 16'sd333, 16'sd4, 16'sd5, 16'sd6);
    checks++; if (frame_valid !== 1'b0 || link_state !== 2'd2) begin errors++; $display("FAIL flags02 got valid=%b st=%0d want 0 2", frame_valid, link_state); end
    idle(TIMEOUT_CYC - 1);
    checks++; if (link_state !== 2'd2 || timeout_pulse !== 1'b0) begin errors++; $display("FAIL timer_restart got st=%0d to=%b want 2 0", link_state, timeout_pulse); end
    idle(1);
    checks++; if (timeout_pulse !== 1'b1 || link_state !== 2'd0 || link_up !== 1'b0) begin errors++; $display("FAIL timeout_fire got to=%b st=%0d up=%b want 1 0 0", timeout_pulse, link_state, link_up); end
    idle(1);
    checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL timeout_oneshot got %b want 0", timeout_pulse); end
    $display("test_flags_timeout done");
  endtask

  task automatic test_fault();
    acquire();
    checks++; if (link_state !== 2'd2) begin errors++; $display("FAIL fault_pre got st=%0d want 2", link_state); end
    frame_ready = 1'b0;
    send_pkt(1'b1, 2'b01, 16'sd555, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
    for (int i = 0; i < MAX_ERR; i++) begin
      send_pkt(1'b0, 2'b11, 16'sd9, 16'sd9, 16'sd9, 16'sd9, 16'sd9, 16'sd9);
      checks++;
      if (link_state !== ((i < MAX_ERR - 1) ? 2'd2 : 2'd3)) begin errors++; $display("FAIL fault_bad%0d got st=%0d", i, link_state); end
    end
    checks++; if (err_cnt !== 8'd4) begin errors++; $display("FAIL fault_errcnt got %0d want 4", err_cnt); end
    idle(1499);
    send_pkt(1'b1, 2'b01, 16'sd777, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
    checks++; if (link_state !== 2'd3 || f_roll !== 16'sd555) begin errors++; $display("FAIL fault_ignore got st=%0d roll=%0d want 3 555", link_state, f_roll); end
    idle(1499);
    checks++; if (link_state !== 2'd3) begin errors++; $display("FAIL holdoff_end-1 got st=%0d want 3", link_state); end
    idle(1);
    checks++; if (link_state !== 2'd0) begin errors++; $display("FAIL holdoff_end got st=%0d want 0", link_state); end
    checks++; if (frame_valid !== 1'b1 || f_roll !== 16'sd555) begin errors++; $display("FAIL pending_kept got v=%b roll=%0d want 1 555", frame_valid, f_roll); end
    send_pkt(1'b1, 2'b00, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
    checks++; if (link_state !== 2'd1 || frame_valid !== 1'b1) begin errors++; $display("FAIL reacq got st=%0d v=%b want 1 1", link_state, frame_valid); end
    $display("test_fault done");
  endtask

  task automatic test_reset_mid_acq();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (link_state !== 2'd0 || link_up !== 1'b0 || timeout_pulse !== 1'b0) begin errors++; $display("FAIL midrst_state got st=%0d up=%b to=%b want 0", link_state, link_up, timeout_pulse); end
    checks++; if (frame_valid !== 1'b0 || f_roll !== 16'sd0 || f_gyro_ok !== 1'b0) begin errors++; $display("FAIL midrst_frame got v=%b roll=%0d want 0 0", frame_valid, f_roll); end
    checks++; if (err_cnt !== '0 || overrun_cnt !== '0) begin errors++; $display("FAIL midrst_cnt got err=%0d ovr=%0d want 0 0", err_cnt, overrun_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    $display("test_reset_mid_acq done");
  endtask

  task automatic test_err_run();
    logic [6:0] pattern;
    pattern = 7'b1110111;
    frame_ready = 1'b1;
    acquire();
    for (int i = 0; i < 7; i++) begin
      send_pkt(~pattern[i], 2'b00, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
      checks++; if (link_state !== 2'd2) begin errors++; $display("FAIL errrun_pkt%0d got st=%0d want 2", i, link_state); end
    end
    checks++; if (err_cnt !== 8'd6 || link_up !== 1'b1) begin errors++; $display("FAIL errrun_cnt got err=%0d up=%b want 6 1", err_cnt, link_up); end
    $display("test_err_run done");
  endtask

  task automatic test_overrun();
    frame_ready = 1'b0;
    send_pkt(1'b1, 2'b01, 16'sh7fff, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1);
    checks++; if (frame_valid !== 1'b1 || overrun_cnt !== 8'd0 || f_roll !== 16'sh7fff) begin errors++; $display("FAIL ovr_first got v=%b ovr=%0d roll=%0d want 1 0 32767", frame_valid, overrun_cnt, f_roll); end
    send_pkt(1'b1, 2'b01, 16'sh8000, 16'sd2, 16'sd2, 16'sd2, 16'sd2, 16'sd2);
    checks++; if (overrun_cnt !== 8'd1 || f_roll !== 16'sh8000) begin errors++; $display("FAIL ovr_second got ovr=%0d roll=%0d want 1 -32768", overrun_cnt, f_roll); end
    frame_ready = 1'b1;
    send_pkt(1'b1, 2'b01, 16'sd1234, 16'sd3, 16'sd3, 16'sd3, 16'sd3, 16'sd3);
    checks++; if (overrun_cnt !== 8'd1 || frame_valid !== 1'b1 || f_roll !== 16'sd1234) begin errors++; $display("FAIL ovr_handshake got ovr=%0d v=%b roll=%0d want 1 1 1234", overrun_cnt, frame_valid, f_roll); end
    idle(1);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got v=%b want 0", frame_valid); end
    $display("test_overrun done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 5000; c++) begin
      checks++; if (link_state !== 2'(m_state) || link_up !== (m_state == 2)) begin errors++; $display("FAIL rnd_state cyc%0d got st=%0d up=%b want %0d", c, link_state, link_up, m_state); end
      checks++; if (timeout_pulse !== m_pulse || frame_valid !== m_fv) begin errors++; $display("FAIL rnd_flags cyc%0d got to=%b v=%b want %b %b", c, timeout_pulse, frame_valid, m_pulse, m_fv); end
      checks++; if (err_cnt !== CNT_W'(m_err) || overrun_cnt !== CNT_W'(m_ovr)) begin errors++; $display("FAIL rnd_cnt cyc%0d got err=%0d ovr=%0d want %0d %0d", c, err_cnt, overrun_cnt, m_err, m_ovr); end
      checks++;
      if ({f_roll, f_pitch, f_yaw, f_gx, f_gy, f_gz, f_gyro_ok} !== {m_roll, m_pitch, m_yaw, m_gx, m_gy, m_gz, m_gok}) begin
        errors++; $display("FAIL rnd_frame cyc%0d got roll=%0d gz=%0d want %0d %0d", c, f_roll, f_gz, m_roll, m_gz);
      end
      pkt_done    = ($urandom_range(0, 2) == 0);
      hdr_ok      = ($urandom_range(0, 99) < 85);
      euler_ok    = $urandom_range(0, 1) == 1;
      gyro_ok     = $urandom_range(0, 1) == 1;
      frame_ready = $urandom_range(0, 1) == 1;
      roll = 16'($urandom); pitch = 16'($urandom); yaw = 16'($urandom);
      gx   = 16'($urandom); gy    = 16'($urandom); gz  = 16'($urandom);
      @(negedge clk);
    end
    pkt_done = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    rst_n = 1'b0; pkt_done = 1'b0; hdr_ok = 1'b0; euler_ok = 1'b0; gyro_ok = 1'b0;
    frame_ready = 1'b0; roll = '0; pitch = '0; yaw = '0; gx = '0; gy = '0; gz = '0;
    @(negedge clk);
    test_reset();
    test_acquisition();
    test_flags_timeout();
    test_fault();
    test_reset_mid_acq();
    test_err_run();
    test_overrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
